spi_master_cfg: RTL

//  Parametrised SPI master. Successor to the fixed 8-bit single-slave master.

---
 rtl/spi_master_cfg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master: DATA_W-bit words, CLK_DIV divider, all four SPI modes, NUM_SS selects.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input (LSB-first shifting); default is MSB first.
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 1,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD, ST_GAP} state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DIV_W-1:0]    div_r;
  logic [EDGE_W-1:0]   edge_r;
  logic [DATA_W-1:0]   tx_sh_r;
  logic [DATA_W-1:0]   rx_sh_r;
  logic                cpha_r;
  logic                lsb_r;
  logic                lsb_in_s;
  logic                tick_s;
  logic                lead_s;
  logic                last_edge_s;
  logic                accept_s;
  logic                toggle_s;
  logic                sample_s;
  logic                drive_s;
  logic                done_s;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_s = lsb_first;
`else
  assign lsb_in_s = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    first_bit = lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    shift_out = lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    shift_in = lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices leave every select deasserted.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    ss_decode = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == SS_W'(i)) ss_decode[i] = 1'b0;
    end
  endfunction

  assign tick_s      = (state_r != ST_IDLE) && (div_r == DIV_W'(CLK_DIV - 1));
  assign lead_s      = ~edge_r[0];
  assign last_edge_s = (edge_r == EDGE_W'(2 * DATA_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state decode; every non-IDLE state advances on a divider tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (tx_valid)                state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
      ST_SETUP: if (tick_s)                  state_nxt_s = ST_XFER;  else state_nxt_s = ST_SETUP;
      ST_XFER:  if (tick_s && last_edge_s)   state_nxt_s = ST_HOLD;  else state_nxt_s = ST_XFER;
      ST_HOLD:  if (tick_s)                  state_nxt_s = ST_GAP;   else state_nxt_s = ST_HOLD;
      ST_GAP:   if (tick_s)                  state_nxt_s = ST_IDLE;  else state_nxt_s = ST_GAP;
      default:                               state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state strobes; leading edges sample when cpha=0, trailing edges sample when cpha=1.
  always_comb begin
    accept_s = 1'b0;
    toggle_s = 1'b0;
    sample_s = 1'b0;
    drive_s  = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = tx_valid;
      ST_XFER: begin
        toggle_s = tick_s;
        sample_s = tick_s & (lead_s ^ cpha_r);
        drive_s  = tick_s & ~(lead_s ^ cpha_r) & ~(~cpha_r & last_edge_s);
      end
      ST_HOLD: done_s = tick_s;
      default: done_s = 1'b0;
    endcase
  end

  // Datapath and registered pin/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r    <= '0;
      edge_r   <= '0;
      tx_sh_r  <= '0;
      rx_sh_r  <= '0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
    end else begin
      if ((state_r == ST_IDLE) || tick_s) div_r <= '0;
      else                                div_r <= div_r + 1'b1;

      if (state_r != ST_XFER) edge_r <= '0;
      else if (toggle_s)      edge_r <= edge_r + 1'b1;

      rx_valid <= done_s;
      tx_ready <= (state_nxt_s == ST_IDLE);
      busy     <= (state_nxt_s != ST_IDLE);

      if (accept_s) begin
        cpha_r  <= cpha;
        lsb_r   <= lsb_in_s;
        rx_sh_r <= '0;
        sclk    <= cpol;
        ss_n    <= ss_decode(ss_sel);
        // cpha=0 presents the first bit before the first leading edge.
        if (cpha) begin
          tx_sh_r <= tx_data;
        end else begin
          tx_sh_r <= shift_out(tx_data, lsb_in_s);
          mosi    <= first_bit(tx_data, lsb_in_s);
        end
      end else if (state_r == ST_IDLE) begin
        sclk <= cpol;
        ss_n <= '1;
      end else begin
        if (toggle_s) sclk <= ~sclk;
        if (drive_s) begin
          mosi    <= first_bit(tx_sh_r, lsb_r);
          tx_sh_r <= shift_out(tx_sh_r, lsb_r);
        end
        if (sample_s) rx_sh_r <= shift_in(rx_sh_r, miso, lsb_r);
        if (done_s) begin
          ss_n    <= '1;
          rx_data <= rx_sh_r;
        end
      end
    end
  end

endmodule
